// File: rtl/maxpool_ctrl.sv
// 2x2 stride-2 max-pool controller: buffers even rows, pairs them with the odd row
// and drives an external max-of-4 comparator, one pooled result per handshake.
module maxpool_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] cmp_num1,
    output logic [7:0] cmp_num2,
    output logic [7:0] cmp_num3,
    output logic [7:0] cmp_num4,
    input  logic [7:0] cmp_big,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [2:0] {IDLE, EVEN_ROW, ODD_ROW, OUT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    hold;
    logic [7:0]    lbuf [IMG_W];
    logic          acc;
    logic [CW-1:0] col_even;

    assign acc      = in_valid && in_ready;
    assign col_even = {col[CW-1:1], 1'b0};
    assign out_data = cmp_big;

    // Line buffer carries no reset; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (state == EVEN_ROW && acc)
            lbuf[col] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            hold      <= '0;
            cmp_num1  <= '0;
            cmp_num2  <= '0;
            cmp_num3  <= '0;
            cmp_num4  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= EVEN_ROW;
                        col      <= '0;
                        row      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                EVEN_ROW: begin
                    if (acc) begin
                        if (col == COL_LAST) begin
                            col   <= '0;
                            row   <= row + RW'(1);
                            state <= ODD_ROW;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                ODD_ROW: begin
                    if (acc) begin
                        if (!col[0]) begin
                            hold <= in_data;
                            col  <= col + CW'(1);
                        end else begin
                            cmp_num1  <= lbuf[col_even];
                            cmp_num2  <= lbuf[col];
                            cmp_num3  <= hold;
                            cmp_num4  <= in_data;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= OUT;
                            if (col == COL_LAST) begin
                                col <= '0;
                                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                end
                OUT: begin
                    // col/row already point past the window; row==0 at col==0 means frame wrapped.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (col != '0) begin
                            state    <= ODD_ROW;
                            in_ready <= 1'b1;
                        end else if (row != '0) begin
                            state    <= EVEN_ROW;
                            in_ready <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_maxpool_ctrl.sv
// Scoreboard bench: instance 0 is a 4x2 frame, instance 1 a 4x4 frame, both sharing
// clock and reset; a negedge monitor pops expected pooled values on each handshake.
module tb_maxpool_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st [2], iv [2], ordy [2], ir [2], ov [2], bsy [2], dn [2];
    logic [7:0] id [2], c1 [2], c2 [2], c3 [2], c4 [2], big [2], od [2];

    int errors = 0;
    int checks = 0;
    int hs_cnt [2];
    int dn_cnt [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    always #5 clk = ~clk;

    function automatic logic [7:0] max4(input logic [7:0] a, b, c, d);
        logic [7:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cmp
        assign big[g] = max4(c1[g], c2[g], c3[g], c4[g]);
    end

    maxpool_ctrl #(.IMG_W(4), .IMG_H(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(iv[0]), .in_data(id[0]),
        .in_ready(ir[0]), .cmp_num1(c1[0]), .cmp_num2(c2[0]), .cmp_num3(c3[0]),
        .cmp_num4(c4[0]), .cmp_big(big[0]), .out_valid(ov[0]), .out_data(od[0]),
        .out_ready(ordy[0]), .busy(bsy[0]), .done(dn[0]));

    maxpool_ctrl #(.IMG_W(4), .IMG_H(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(iv[1]), .in_data(id[1]),
        .in_ready(ir[1]), .cmp_num1(c1[1]), .cmp_num2(c2[1]), .cmp_num3(c3[1]),
        .cmp_num4(c4[1]), .cmp_big(big[1]), .out_valid(ov[1]), .out_data(od[1]),
        .out_ready(ordy[1]), .busy(bsy[1]), .done(dn[1]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int s, input logic [7:0] v);
        if (s == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    task automatic pop_chk(input int s);
        logic [7:0] e;
        if (qsize(s) == 0) begin
            checks++;
            errors++;
            $display("FAIL out%0d_unexpected: got %0d expected no output", s, od[s]);
        end else begin
            e = (s == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("out%0d_data", s), od[s], e);
        end
    endtask

    // Handshake completes at the next posedge; ordy only changes at posedge+1.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int s = 0; s < 2; s++) begin
                if (ov[s] && ordy[s]) begin
                    hs_cnt[s]++;
                    pop_chk(s);
                end
                if (dn[s]) dn_cnt[s]++;
            end
        end
    end

    task automatic start_frame(input int s);
        @(posedge clk); #1 st[s] = 1'b1;
        @(posedge clk); #1 st[s] = 1'b0;
    endtask

    task automatic send(input int s, input logic [7:0] v, input int gap);
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        iv[s] = 1'b1;
        id[s] = v;
        n = 0;
        @(negedge clk);
        while (!ir[s] && n < 100) begin @(negedge clk); n++; end
        if (!ir[s]) chk($sformatf("in_ready%0d_timeout", s), ir[s], 1);
        @(posedge clk); #1 iv[s] = 1'b0;
    endtask

    task automatic wait_done(input int s, input int dc0, input int hs0, input int nout);
        int n;
        n = 0;
        while (!dn[s] && n < 400) begin @(negedge clk); n++; end
        chk($sformatf("done%0d_seen", s), dn[s], 1);
        @(negedge clk);
        chk($sformatf("busy%0d_fall", s), bsy[s], 0);
        chk($sformatf("done%0d_pulses", s), dn_cnt[s] - dc0, 1);
        chk($sformatf("hs%0d_count", s), hs_cnt[s] - hs0, nout);
        chk($sformatf("q%0d_empty", s), qsize(s), 0);
    endtask

    initial begin
        int dc, hs, n;
        logic [7:0] rowsA [8];
        rowsA = '{8'd1, 8'd9, 8'd3, 8'd4, 8'd5, 8'd2, 8'd8, 8'd7};
        for (int s = 0; s < 2; s++) begin
            st[s] = 0; iv[s] = 0; id[s] = 0; ordy[s] = 1; hs_cnt[s] = 0; dn_cnt[s] = 0;
        end

        // Reset state, while asserted and first cycle after release
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_in_ready", ir[s], 0);
            chk("rst_out_valid", ov[s], 0);
            chk("rst_busy", bsy[s], 0);
            chk("rst_done", dn[s], 0);
            chk("rst_cmp", {c1[s], c2[s], c3[s], c4[s]}, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", ir[0], 0);
        chk("rel_busy", bsy[0], 0);
        chk("rel_out_valid", ov[1], 0);

        // 4x2 frame, consumer always ready: 9 then 8
        push(0, 8'd9); push(0, 8'd8);
        dc = dn_cnt[0]; hs = hs_cnt[0];
        start_frame(0);
        for (int i = 0; i < 8; i++) send(0, rowsA[i], 0);
        wait_done(0, dc, hs, 2);

        // Consumer stalls 5 cycles on the first result
        push(0, 8'd9); push(0, 8'd8);
        dc = dn_cnt[0]; hs = hs_cnt[0];
        @(posedge clk); #1 ordy[0] = 1'b0;
        fork
            begin
                start_frame(0);
                for (int i = 0; i < 8; i++) send(0, rowsA[i], 0);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!ov[0] && n < 200) begin @(negedge clk); n++; end
                repeat (5) begin
                    chk("stall_valid", ov[0], 1);
                    chk("stall_data", od[0], 9);
                    chk("stall_in_ready", ir[0], 0);
                    @(negedge clk);
                end
                @(posedge clk); #1 ordy[0] = 1'b1;
            end
        join
        wait_done(0, dc, hs, 2);

        // 4x4 frame of 0..15
        foreach (q1[i]) ;
        push(1, 8'd5); push(1, 8'd7); push(1, 8'd13); push(1, 8'd15);
        dc = dn_cnt[1]; hs = hs_cnt[1];
        start_frame(1);
        for (int i = 0; i < 16; i++) send(1, 8'(i), 0);
        wait_done(1, dc, hs, 4);

        // Reset after 6 pixels; held result is never consumed
        @(posedge clk); #1 ordy[1] = 1'b0;
        start_frame(1);
        for (int i = 0; i < 6; i++) send(1, 8'(200 + i), 0);
        @(negedge clk);
        chk("pre_rst_valid", ov[1], 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", ov[1], 0);
        chk("midrst_busy", bsy[1], 0);
        chk("midrst_cmp1", c1[1], 0);
        @(posedge clk); #1 rst_n = 1'b1; ordy[1] = 1'b1;
        @(negedge clk);
        chk("midrel_in_ready", ir[1], 0);
        push(1, 8'd15); push(1, 8'd13); push(1, 8'd7); push(1, 8'd5);
        dc = dn_cnt[1]; hs = hs_cnt[1];
        start_frame(1);
        for (int i = 0; i < 16; i++) send(1, 8'(15 - i), 0);
        wait_done(1, dc, hs, 4);

        // start held high through the odd row is ignored
        push(1, 8'd5); push(1, 8'd7); push(1, 8'd13); push(1, 8'd15);
        dc = dn_cnt[1]; hs = hs_cnt[1];
        start_frame(1);
        for (int i = 0; i < 4; i++) send(1, 8'(i), 0);
        st[1] = 1'b1;
        for (int i = 4; i < 8; i++) send(1, 8'(i), 0);
        st[1] = 1'b0;
        for (int i = 8; i < 16; i++) send(1, 8'(i), 0);
        wait_done(1, dc, hs, 4);

        // All 0xFF with random in_valid gaps
        for (int i = 0; i < 4; i++) push(1, 8'hFF);
        dc = dn_cnt[1]; hs = hs_cnt[1];
        start_frame(1);
        for (int i = 0; i < 16; i++) send(1, 8'hFF, int'($urandom_range(0, 3)));
        wait_done(1, dc, hs, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
